fetch_stage: RTL

Instruction-fetch stage driven by the core's four-phase one-hot sequencer. It consumes the phase vector, issues the instruction-memory read in phase 1, latches the returned word in phase 2, and advances or redirects the PC in phase 4. It owns the architectural PC, the instruction register presented to decode, the halt state, and sticky fault flags for malformed phase input and misaligned redirects.

---
 rtl/core_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: definitions shared by every consumer of the core's four-phase sequencer.
//   PH_*             bit positions inside the one-hot phase vector {s1,s2,s3,s4}
//   INSTR_BYTES      size of one instruction word in bytes (PC increment)
//   RESET_PC_DEFAULT default architectural PC after reset
//   phase_is_legal() true when at most one phase bit is set (idle or one-hot)
package core_pkg;

   localparam int unsigned PH_FETCH  = 3;
   localparam int unsigned PH_LATCH  = 2;
   localparam int unsigned PH_EXEC   = 1;
   localparam int unsigned PH_RETIRE = 0;

   localparam int unsigned INSTR_BYTES = 4;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Clearing the lowest set bit leaves zero only for idle or one-hot vectors.
   function automatic logic phase_is_legal(input logic [3:0] ph);
      return (ph & (ph - 4'd1)) == 4'd0;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory read port.
//   imem_en    read enable, driven by the fetch stage
//   imem_addr  read address, driven by the fetch stage
//   imem_rdata read data, returned by memory one cycle after imem_en
// Modports: master = fetch stage side, slave = memory side.
interface fetch_stage_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;

   modport master (
      output imem_en,
      output imem_addr,
      input  imem_rdata
   );

   modport slave (
      input  imem_en,
      input  imem_addr,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch driven by the one-hot phase sequencer.
// Issues the memory read in s1, captures the word in s2, advances or redirects the PC in s4.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   phase             one-hot {s1,s2,s3,s4}, bit3 = s1; zero = idle
//   redirect, redirect_target, halt_req   control, sampled only in s4
//   imem              instruction-memory read port (master side)
//   instr, instr_pc, instr_valid          instruction register for decode
//   pc, halted        architectural PC and halt state
//   phase_err         sticky: more than one phase bit seen
//   misalign_err      sticky: redirect target with nonzero low bits
//   fetch_count       words latched, wrapping
module fetch_stage
   import core_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
   parameter int unsigned       COUNT_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         phase,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_target,
   input  logic               halt_req,
   fetch_stage_if.master      imem,
   output logic [DATA_W-1:0]  instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic               halted,
   output logic               phase_err,
   output logic               misalign_err,
   output logic [COUNT_W-1:0] fetch_count
);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [DATA_W-1:0]  instr_q, instr_d;
   logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
   logic               instr_valid_q, instr_valid_d;
   logic               halted_q, halted_d;
   logic               phase_err_q, phase_err_d;
   logic               misalign_err_q, misalign_err_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               pending_q, pending_d;

   logic phase_ok;
   logic imem_en_w;
   logic do_latch;
   logic do_retire;

   always_comb begin
      phase_ok  = phase_is_legal(phase);
      imem_en_w = phase[PH_FETCH] & ~halted_q & ~phase_err_q;
      // Memory data is only valid in the cycle directly after the read was issued.
      do_latch  = phase_ok & phase[PH_LATCH] & pending_q;
      do_retire = phase_ok & phase[PH_RETIRE] & ~halted_q;
   end

   always_comb begin
      pc_d           = pc_q;
      instr_d        = instr_q;
      instr_pc_d     = instr_pc_q;
      instr_valid_d  = instr_valid_q;
      halted_d       = halted_q;
      phase_err_d    = phase_err_q;
      misalign_err_d = misalign_err_q;
      count_d        = count_q;
      // A malformed phase cycle must not leave a read outstanding.
      pending_d      = imem_en_w & phase_ok;

      if (!phase_ok) begin
         phase_err_d = 1'b1;
      end

      if (do_latch) begin
         instr_d       = imem.imem_rdata;
         instr_pc_d    = pc_q;
         instr_valid_d = 1'b1;
         count_d       = count_q + COUNT_W'(1);
      end

      if (do_retire) begin
         if (redirect) begin
            pc_d = {redirect_target[ADDR_W-1:2], 2'b00};
            if (|redirect_target[1:0]) begin
               misalign_err_d = 1'b1;
            end
         end else begin
            pc_d = pc_q + ADDR_W'(INSTR_BYTES);
         end
         if (halt_req) begin
            halted_d      = 1'b1;
            instr_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q           <= RESET_PC;
         instr_q        <= '0;
         instr_pc_q     <= '0;
         instr_valid_q  <= 1'b0;
         halted_q       <= 1'b0;
         phase_err_q    <= 1'b0;
         misalign_err_q <= 1'b0;
         count_q        <= '0;
         pending_q      <= 1'b0;
      end else begin
         pc_q           <= pc_d;
         instr_q        <= instr_d;
         instr_pc_q     <= instr_pc_d;
         instr_valid_q  <= instr_valid_d;
         halted_q       <= halted_d;
         phase_err_q    <= phase_err_d;
         misalign_err_q <= misalign_err_d;
         count_q        <= count_d;
         pending_q      <= pending_d;
      end
   end

   assign imem.imem_en   = imem_en_w;
   assign imem.imem_addr = pc_q;
   assign instr          = instr_q;
   assign instr_pc       = instr_pc_q;
   assign instr_valid    = instr_valid_q;
   assign pc             = pc_q;
   assign halted         = halted_q;
   assign phase_err      = phase_err_q;
   assign misalign_err   = misalign_err_q;
   assign fetch_count    = count_q;

endmodule
